// File: rtl/udp_frame_tx.sv
// ---------------------------------------------------------------------------
// udp_frame_tx
//
// Builds one Ethernet/IPv4/UDP frame per accepted request and streams it onto
// a GMII transmit interface: preamble, SFD, 42 header bytes, the UDP payload
// pulled from a byte stream, zero padding up to the 60-byte minimum body, the
// CRC-32 FCS, then an inter-frame gap.
//
// Ports
//   clk          GMII transmit clock, all logic on the rising edge
//   RSTn         asynchronous active-low reset
//   start        frame request, sampled only while idle
//   payload_len  UDP payload length in bytes, sampled with start
//   pay_data     payload byte
//   pay_valid    pay_data valid
//   pay_ready    payload byte is consumed at the end of this cycle
//   busy         high from the accepted start through the end of the gap
//   len_err      one-cycle pulse when a start is rejected for length
//   TX_EN        GMII transmit enable
//   TX_ER        GMII transmit error
//   MAC_Data     GMII transmit byte
//
// Timing: every output is a register. The FSM state names the byte being
// prepared, which appears on MAC_Data one cycle later, so the IDLE cycle that
// accepts start already prepares the first preamble byte. Likewise pay_ready
// is high exactly while the FSM is in PAYLOAD, and the byte consumed in that
// cycle is on MAC_Data in the next one.
// ---------------------------------------------------------------------------
module udp_frame_tx #(
    parameter logic [47:0] SRC_MAC     = 48'h00_12_34_56_78_90,
    parameter logic [47:0] DST_MAC     = 48'h08_1F_71_02_C7_77,
    parameter logic [31:0] SRC_IP      = 32'hC0A8_002C,
    parameter logic [31:0] DST_IP      = 32'hC0A8_0002,
    parameter logic [15:0] SRC_PORT    = 16'd5000,
    parameter logic [15:0] DST_PORT    = 16'd6000,
    parameter int unsigned MAX_PAYLOAD = 1472,
    parameter int unsigned IFG_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        start,
    input  logic [10:0] payload_len,
    input  logic [7:0]  pay_data,
    input  logic        pay_valid,
    output logic        pay_ready,
    output logic        busy,
    output logic        len_err,
    output logic        TX_EN,
    output logic        TX_ER,
    output logic [7:0]  MAC_Data
);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StHeader,
        StPayload,
        StPad,
        StFcs,
        StIfg
    } state_e;

    // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    // IPv4 header checksum; only total_len varies between frames.
    function automatic logic [15:0] ip_csum(input logic [10:0] len);
        logic [31:0] s;
        s = 32'h0000_4500 + 32'(16'd28 + 16'(len)) + 32'h0000_4011
          + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0])
          + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
        // Two folds are enough for a sum of seven 16-bit words.
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return ~s[15:0];
    endfunction

    state_e       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [10:0]  len_q, len_d;
    logic [15:0]  csum_q, csum_d;
    logic [31:0]  crc_q, crc_d;
    logic         err_q, err_d;

    logic         tx_en_q, tx_en_d;
    logic         tx_er_q, tx_er_d;
    logic [7:0]   data_q, data_d;
    logic         pay_ready_q, pay_ready_d;
    logic         busy_q, busy_d;
    logic         len_err_q, len_err_d;

    logic         start_idle;
    logic         len_ok;
    logic         accept;
    logic [15:0]  total_len;
    logic [15:0]  udp_len;
    logic [335:0] hdr_vec;
    logic [5:0]   hdr_idx;
    logic [7:0]   hdr_byte;
    logic [7:0]   fcs_byte;
    logic [15:0]  pay_last;
    logic [15:0]  pad_last;

    assign start_idle = (state_q == StIdle) && start;
    assign len_ok     = (32'(payload_len) <= MAX_PAYLOAD);
    assign accept     = start_idle && len_ok;

    assign total_len = 16'd28 + 16'(len_q);
    assign udp_len   = 16'd8 + 16'(len_q);

    // Header byte 0 sits in the most significant byte.
    assign hdr_vec = {DST_MAC, SRC_MAC, 16'h0800,
                      8'h45, 8'h00, total_len, 16'h0000, 16'h0000,
                      8'h40, 8'h11, csum_q, SRC_IP, DST_IP,
                      SRC_PORT, DST_PORT, udp_len, 16'h0000};
    assign hdr_idx  = 6'd41 - cnt_q[5:0];
    assign hdr_byte = hdr_vec[{hdr_idx, 3'b000} +: 8];

    // FCS goes out as ~CRC, least significant byte first.
    assign fcs_byte = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];

    // Only meaningful in PAYLOAD (len_q > 0) and PAD (len_q < 18).
    assign pay_last = 16'(len_q) - 16'd1;
    assign pad_last = 16'd17 - 16'(len_q);

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            len_q       <= 11'd0;
            csum_q      <= 16'd0;
            crc_q       <= 32'd0;
            err_q       <= 1'b0;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            data_q      <= 8'h00;
            pay_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            crc_q       <= crc_d;
            err_q       <= err_d;
            tx_en_q     <= tx_en_d;
            tx_er_q     <= tx_er_d;
            data_q      <= data_d;
            pay_ready_q <= pay_ready_d;
            busy_q      <= busy_d;
            len_err_q   <= len_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    // The accepting cycle prepares preamble byte 0 itself.
                    state_d = StPreamble;
                    cnt_d   = 16'd1;
                end
            end
            StPreamble: begin
                if (cnt_q == 16'd6) begin
                    state_d = StSfd;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSfd: begin
                state_d = StHeader;
                cnt_d   = 16'd0;
            end
            StHeader: begin
                if (cnt_q == 16'd41) begin
                    state_d = (len_q == 11'd0) ? StPad : StPayload;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StPayload: begin
                if (cnt_q == pay_last) begin
                    state_d = (len_q < 11'd18) ? StPad : StFcs;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StPad: begin
                if (cnt_q == pad_last) begin
                    state_d = StFcs;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StFcs: begin
                if (cnt_q == 16'd3) begin
                    state_d = StIfg;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StIfg: begin
                // One extra cycle here: the last FCS byte is still on the bus
                // during the first IFG cycle.
                if (cnt_q == 16'(IFG_CYCLES)) begin
                    state_d = StIdle;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: next values of the output registers
    // -----------------------------------------------------------------------
    always_comb begin
        tx_en_d     = 1'b0;
        tx_er_d     = 1'b0;
        data_d      = 8'h00;
        err_d       = err_q;
        pay_ready_d = (state_d == StPayload);
        busy_d      = (state_d != StIdle);
        len_err_d   = start_idle && !len_ok;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    tx_en_d = 1'b1;
                    data_d  = 8'h55;
                    err_d   = 1'b0;
                end
            end
            StPreamble: begin
                tx_en_d = 1'b1;
                data_d  = 8'h55;
            end
            StSfd: begin
                tx_en_d = 1'b1;
                data_d  = 8'hD5;
            end
            StHeader: begin
                tx_en_d = 1'b1;
                data_d  = hdr_byte;
            end
            StPayload: begin
                tx_en_d = 1'b1;
                data_d  = pay_data;
                // A missing byte poisons the rest of the frame.
                if (!pay_valid) begin
                    err_d = 1'b1;
                end
            end
            StPad: begin
                tx_en_d = 1'b1;
            end
            StFcs: begin
                tx_en_d = 1'b1;
                data_d  = fcs_byte;
            end
            default: ;
        endcase
        if (tx_en_d && err_d) begin
            tx_er_d = 1'b1;
            data_d  = 8'h00;
        end
    end

    // -----------------------------------------------------------------------
    // Per-frame datapath: latched length, IP checksum, running CRC
    // -----------------------------------------------------------------------
    always_comb begin
        len_d  = len_q;
        csum_d = csum_q;
        crc_d  = crc_q;
        if (accept) begin
            len_d  = payload_len;
            csum_d = ip_csum(payload_len);
            crc_d  = 32'hFFFF_FFFF;
        end else if (state_q inside {StHeader, StPayload, StPad}) begin
            crc_d = crc32_byte(crc_q, data_d);
        end
    end

    assign TX_EN     = tx_en_q;
    assign TX_ER     = tx_er_q;
    assign MAC_Data  = data_q;
    assign pay_ready = pay_ready_q;
    assign busy      = busy_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_udp_frame_tx.sv
module tb_udp_frame_tx;

    localparam logic [47:0] SRC_MAC  = 48'h00_12_34_56_78_90;
    localparam logic [47:0] DST_MAC  = 48'h08_1F_71_02_C7_77;
    localparam logic [31:0] SRC_IP   = 32'hC0A8_002C;
    localparam logic [31:0] DST_IP   = 32'hC0A8_0002;
    localparam logic [15:0] SRC_PORT = 16'd5000;
    localparam logic [15:0] DST_PORT = 16'd6000;
    localparam int          IFG      = 12;

    logic        clk;
    logic        RSTn;
    logic        start;
    logic [10:0] payload_len;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_ready;
    logic        busy;
    logic        len_err;
    logic        TX_EN;
    logic        TX_ER;
    logic [7:0]  MAC_Data;

    udp_frame_tx dut (
        .clk         (clk),
        .RSTn        (RSTn),
        .start       (start),
        .payload_len (payload_len),
        .pay_data    (pay_data),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .busy        (busy),
        .len_err     (len_err),
        .TX_EN       (TX_EN),
        .TX_ER       (TX_ER),
        .MAC_Data    (MAC_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] pay_mem [0:2047];
    logic [7:0] exp_q [$];
    logic       exp_er [$];

    typedef struct {
        int len;    // payload length
        int drop;   // payload index with pay_valid=0, -1 none
        int poke;   // cycle of a stray start during the frame, -1 none
        int pat;    // 0: bytes 00,01,.. 1: random
        int burst;  // expected TX_EN burst length
        int tot;    // expected IPv4 total_len
        int udp;    // expected UDP length
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    endtask

    // Bit-serial reflected CRC-32, one message bit at a time.
    function automatic logic [31:0] crc_bits(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ b[k];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB8_8320;
        end
        return c;
    endfunction

    // Reference frame built from the protocol field definitions.
    task automatic build_expected(input int len, input int drop);
        logic [7:0]  hdr [42];
        logic [7:0]  body [$];
        logic [47:0] dm, sm;
        logic [31:0] si, di, crc;
        logic [15:0] sp, dp, tl, ul, cs;
        int unsigned s;
        dm = DST_MAC; sm = SRC_MAC; si = SRC_IP; di = DST_IP; sp = SRC_PORT; dp = DST_PORT;
        tl = 16'(28 + len);
        ul = 16'(8 + len);
        for (int i = 0; i < 6; i++) begin
            hdr[i]     = dm[8*(5-i) +: 8];
            hdr[6 + i] = sm[8*(5-i) +: 8];
        end
        hdr[12] = 8'h08; hdr[13] = 8'h00;
        hdr[14] = 8'h45; hdr[15] = 8'h00; hdr[16] = tl[15:8]; hdr[17] = tl[7:0];
        hdr[18] = 8'h00; hdr[19] = 8'h00; hdr[20] = 8'h00; hdr[21] = 8'h00;
        hdr[22] = 8'h40; hdr[23] = 8'h11; hdr[24] = 8'h00; hdr[25] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            hdr[26 + i] = si[8*(3-i) +: 8];
            hdr[30 + i] = di[8*(3-i) +: 8];
        end
        hdr[34] = sp[15:8]; hdr[35] = sp[7:0];
        hdr[36] = dp[15:8]; hdr[37] = dp[7:0];
        hdr[38] = ul[15:8]; hdr[39] = ul[7:0];
        hdr[40] = 8'h00;    hdr[41] = 8'h00;
        s = 0;
        for (int k = 0; k < 10; k++) s += 32'({hdr[14 + 2*k], hdr[15 + 2*k]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        hdr[24] = cs[15:8]; hdr[25] = cs[7:0];

        body.delete();
        for (int i = 0; i < 42; i++) body.push_back(hdr[i]);
        for (int i = 0; i < len; i++) body.push_back(pay_mem[i]);
        while (body.size() < 60) body.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        foreach (body[i]) crc = crc_bits(crc, body[i]);
        crc = ~crc;

        exp_q.delete();
        exp_er.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (body[i]) exp_q.push_back(body[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
        foreach (exp_q[i]) exp_er.push_back(1'b0);
        if (drop >= 0) begin
            for (int i = 50 + drop; i < exp_q.size(); i++) begin
                exp_q[i]  = 8'h00;
                exp_er[i] = 1'b1;
            end
        end
    endtask

    task automatic fill_payload(input int pat);
        for (int i = 0; i < 2048; i++) pay_mem[i] = (pat == 0) ? 8'(i) : 8'($urandom);
    endtask

    task automatic run_frame(input string tag, input int len, input int drop, input int poke,
                             input int exp_burst, input int exp_tot, input int exp_udp);
        logic [7:0] got [$];
        logic       got_er [$];
        int  idx, cyc, bursts, ready_cnt, ifg_cnt, byte_bad, er_bad, first_bad, extra;
        bit  prev_en, done, timed_out;
        build_expected(len, drop);
        idx = 0; cyc = 0; bursts = 0; ready_cnt = 0; ifg_cnt = 0;
        prev_en = 1'b0; done = 1'b0; timed_out = 1'b0;
        @(negedge clk);
        start       = 1'b1;
        payload_len = 11'(len);
        pay_valid   = 1'b1;
        pay_data    = pay_mem[0];
        @(negedge clk);
        start = 1'b0;
        check({tag, " preamble one cycle after start"}, TX_EN, 1);
        while (!done) begin
            if (TX_EN) begin
                got.push_back(MAC_Data);
                got_er.push_back(TX_ER);
                if (!prev_en) bursts++;
            end else if (bursts > 0 && busy) begin
                ifg_cnt++;
            end
            if (pay_ready) ready_cnt++;
            prev_en = TX_EN;
            if (!busy) begin
                done = 1'b1;
            end else begin
                pay_data  = pay_mem[idx];
                pay_valid = (idx != drop);
                if (pay_ready) idx++;
                if (cyc == poke) begin
                    start       = 1'b1;
                    payload_len = 11'd5;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
                if (cyc > 3000) begin
                    timed_out = 1'b1;
                    done      = 1'b1;
                end
            end
        end
        start     = 1'b0;
        pay_valid = 1'b1;
        check({tag, " frame completes in budget"}, timed_out, 0);
        check({tag, " single TX_EN burst"}, bursts, 1);
        check({tag, " burst length"}, got.size(), exp_burst);
        byte_bad = 0; er_bad = 0; first_bad = -1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (got[i] !== exp_q[i]) begin
                byte_bad++;
                if (first_bad < 0) first_bad = i;
            end
            if (got_er[i] !== exp_er[i]) er_bad++;
        end
        check($sformatf("%s byte mismatches (first at %0d)", tag, first_bad), byte_bad, 0);
        check({tag, " TX_ER pattern mismatches"}, er_bad, 0);
        check({tag, " pay_ready cycles"}, ready_cnt, len);
        check({tag, " IFG idle cycles"}, ifg_cnt, IFG);
        check({tag, " total_len"}, (got.size() > 47) ? longint'({got[24], got[25]}) : -1, exp_tot);
        check({tag, " udp_len"}, (got.size() > 47) ? longint'({got[46], got[47]}) : -1, exp_udp);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (TX_EN) extra++;
        end
        check({tag, " no transmit after frame"}, extra, 0);
    endtask

    int rl, rd, rp, cnt_en;

    initial begin
        tbl[0] = '{22,   -1, -1, 0, 76,   32'h0032, 32'h001E};
        tbl[1] = '{0,    -1, -1, 1, 72,   32'h001C, 32'h0008};
        tbl[2] = '{1472, -1, -1, 1, 1526, 32'h05DC, 32'h05C8};
        tbl[3] = '{22,    5, -1, 0, 76,   32'h0032, 32'h001E};
        tbl[4] = '{17,   -1, -1, 1, 72,   32'h002D, 32'h0019};
        tbl[5] = '{18,   -1, -1, 1, 72,   32'h002E, 32'h001A};
        tbl[6] = '{19,   -1, -1, 1, 73,   32'h002F, 32'h001B};
        tbl[7] = '{20,   -1, 30, 1, 74,   32'h0030, 32'h001C};
        tbl[8] = '{1,     0, -1, 1, 72,   32'h001D, 32'h0009};

        RSTn = 1'b0; start = 1'b0; payload_len = 11'd0; pay_data = 8'h00; pay_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("reset TX_EN", TX_EN, 0);
        check("reset TX_ER", TX_ER, 0);
        check("reset MAC_Data", MAC_Data, 0);
        check("reset pay_ready", pay_ready, 0);
        check("reset busy", busy, 0);
        check("reset len_err", len_err, 0);
        RSTn = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            fill_payload(tbl[i].pat);
            run_frame($sformatf("vec%0d L=%0d", i, tbl[i].len), tbl[i].len, tbl[i].drop,
                      tbl[i].poke, tbl[i].burst, tbl[i].tot, tbl[i].udp);
        end

        // Oversized request: rejected with a single len_err pulse.
        @(negedge clk);
        start = 1'b1; payload_len = 11'd1473;
        @(negedge clk);
        start = 1'b0;
        check("len 1473 len_err pulse", len_err, 1);
        check("len 1473 busy", busy, 0);
        check("len 1473 TX_EN", TX_EN, 0);
        @(negedge clk);
        check("len 1473 len_err one cycle", len_err, 0);
        cnt_en = 0;
        repeat (20) begin
            @(negedge clk);
            if (TX_EN) cnt_en++;
        end
        check("len 1473 no transmit", cnt_en, 0);

        // Reset in the middle of the header abandons the frame.
        fill_payload(1);
        @(negedge clk);
        start = 1'b1; payload_len = 11'd30;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre-reset TX_EN in header", TX_EN, 1);
        RSTn = 1'b0;
        #1;
        check("mid-frame reset TX_EN", TX_EN, 0);
        check("mid-frame reset MAC_Data", MAC_Data, 0);
        check("mid-frame reset busy", busy, 0);
        repeat (3) @(negedge clk);
        RSTn = 1'b1;
        cnt_en = 0;
        repeat (80) begin
            @(negedge clk);
            if (TX_EN || busy) cnt_en++;
        end
        check("no completion after reset", cnt_en, 0);
        run_frame("after reset L=10", 10, -1, -1, 72, 38, 18);

        // Randomized frames against the reference model.
        for (int n = 0; n < 10; n++) begin
            rl = $urandom_range(0, 100);
            rd = (rl > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, rl - 1) : -1;
            rp = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 60) : -1;
            fill_payload(1);
            run_frame($sformatf("rand%0d L=%0d drop=%0d", n, rl, rd), rl, rd, rp,
                      8 + 42 + ((rl < 18) ? 18 : rl) + 4, 28 + rl, 8 + rl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
